// File: rtl/led_blinker_array.sv
// Array of independent LED blinkers sharing one free-running tick prescaler.
// Optional macro LED_MIN_ON_EN: a dropped enable still completes the current ON phase.
module led_blinker_array #(
    parameter int NUM_CH    = 4,
    parameter int PRESCALE  = 1000,
    parameter int ON_TICKS  = 250,
    parameter int OFF_TICKS = 250
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] busy,
    output logic              tick
);

    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    logic [PW-1:0] pre_cnt;
    logic [PW-1:0] pre_next;

    always_comb begin
        pre_next = pre_cnt + PW'(1);
        if (pre_cnt == PRE_LAST) begin
            pre_next = '0;
        end
    end

    // tick is registered from the next count so it is high exactly while pre_cnt == PRESCALE-1
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            pre_cnt <= pre_next;
            tick    <= (pre_next == PRE_LAST);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t        state;
        state_t        state_next;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_next;
        logic          led_r;
        logic          busy_r;

        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            case (state)
                IDLE: begin
                    if (en[i]) begin
                        state_next = ON;
                        cnt_next   = '0;
                    end
                end
                ON: begin
`ifdef LED_MIN_ON_EN
                    // enable only matters at the end of the phase: low ends in IDLE, high keeps blinking
                    if (tick) begin
                        if (cnt == ON_LAST) begin
                            state_next = en[i] ? OFF : IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CW'(1);
                        end
                    end
`else
                    if (!en[i]) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (tick) begin
                        if (cnt == ON_LAST) begin
                            state_next = OFF;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CW'(1);
                        end
                    end
`endif
                end
                OFF: begin
                    if (!en[i]) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (tick) begin
                        if (cnt == OFF_LAST) begin
                            state_next = ON;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        always_ff @(posedge pclk or negedge presetn) begin
            if (!presetn) begin
                state  <= IDLE;
                cnt    <= '0;
                led_r  <= 1'b0;
                busy_r <= 1'b0;
            end else begin
                state  <= state_next;
                cnt    <= cnt_next;
                led_r  <= (state_next == ON);
                busy_r <= (state_next != IDLE);
            end
        end

        assign led[i]  = led_r;
        assign busy[i] = busy_r;
    end

endmodule

// File: tb/tb_led_blinker_array.sv
// Scoreboarded random bench for led_blinker_array: two instances (PRESCALE 1 and 4)
// share one enable bus and are compared against a tick/phase-count reference model.
module tb_led_blinker_array;

    localparam int NCH   = 4;
    localparam int ONT   = 2;
    localparam int OFFT  = 3;
    localparam int PRE_A = 1;
    localparam int PRE_B = 4;

    logic           clk = 1'b0;
    logic           presetn;
    logic [NCH-1:0] en;
    logic [NCH-1:0] led_a, busy_a, led_b, busy_b;
    logic           tick_a, tick_b;

    always #5 clk = ~clk;

    led_blinker_array #(.NUM_CH(NCH), .PRESCALE(PRE_A), .ON_TICKS(ONT), .OFF_TICKS(OFFT)) dut_a (
        .pclk(clk), .presetn(presetn), .en(en), .led(led_a), .busy(busy_a), .tick(tick_a)
    );

    led_blinker_array #(.NUM_CH(NCH), .PRESCALE(PRE_B), .ON_TICKS(ONT), .OFF_TICKS(OFFT)) dut_b (
        .pclk(clk), .presetn(presetn), .en(en), .led(led_b), .busy(busy_b), .tick(tick_b)
    );

    typedef struct {
        logic [NCH-1:0] led_a;
        logic [NCH-1:0] busy_a;
        logic           tick_a;
        logic [NCH-1:0] led_b;
        logic [NCH-1:0] busy_b;
        logic           tick_b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: per channel a mode (0 idle, 1 lit, 2 dark) and the ticks
    // already spent in that phase; ticks follow from edges counted since reset.
    int mode  [2][NCH];
    int tdone [2][NCH];
    int edges [2];

    function automatic int pre_of(input int d);
        return (d == 0) ? PRE_A : PRE_B;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            edges[d] = 0;
            for (int c = 0; c < NCH; c++) begin
                mode[d][c]  = 0;
                tdone[d][c] = 0;
            end
        end
    endtask

    task automatic model_step(input logic [NCH-1:0] e);
        for (int d = 0; d < 2; d++) begin
            bit t;
            t = (edges[d] >= 1) && ((edges[d] % pre_of(d)) == pre_of(d) - 1);
            for (int c = 0; c < NCH; c++) begin
                case (mode[d][c])
                    0: if (e[c]) begin mode[d][c] = 1; tdone[d][c] = 0; end
                    1: begin
`ifdef LED_MIN_ON_EN
                        if (t) begin
                            tdone[d][c]++;
                            if (tdone[d][c] == ONT) begin
                                mode[d][c]  = e[c] ? 2 : 0;
                                tdone[d][c] = 0;
                            end
                        end
`else
                        if (!e[c]) begin
                            mode[d][c] = 0; tdone[d][c] = 0;
                        end else if (t) begin
                            tdone[d][c]++;
                            if (tdone[d][c] == ONT) begin mode[d][c] = 2; tdone[d][c] = 0; end
                        end
`endif
                    end
                    default: begin
                        if (!e[c]) begin
                            mode[d][c] = 0; tdone[d][c] = 0;
                        end else if (t) begin
                            tdone[d][c]++;
                            if (tdone[d][c] == OFFT) begin mode[d][c] = 1; tdone[d][c] = 0; end
                        end
                    end
                endcase
            end
            edges[d]++;
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        for (int c = 0; c < NCH; c++) begin
            x.led_a[c]  = (mode[0][c] == 1);
            x.busy_a[c] = (mode[0][c] != 0);
            x.led_b[c]  = (mode[1][c] == 1);
            x.busy_b[c] = (mode[1][c] != 0);
        end
        x.tick_a = ((edges[0] % PRE_A) == PRE_A - 1);
        x.tick_b = ((edges[1] % PRE_B) == PRE_B - 1);
        return x;
    endfunction

    task automatic drive_step(input logic [NCH-1:0] e);
        en = e;
        model_step(e);
        q.push_back(model_out());
    endtask

    task automatic cycle(input logic [NCH-1:0] e);
        @(negedge clk);
        drive_step(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_led_a"},  32'(led_a),  32'd0);
        chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        chk({tag, "_tick_a"}, 32'(tick_a), 32'd0);
        chk({tag, "_led_b"},  32'(led_b),  32'd0);
        chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
        chk({tag, "_tick_b"}, 32'(tick_b), 32'd0);
    endtask

    // Monitor: every output cycle with a pending expectation is compared.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("led_a",  32'(led_a),  32'(x.led_a));
                chk("busy_a", 32'(busy_a), 32'(x.busy_a));
                chk("tick_a", 32'(tick_a), 32'(x.tick_a));
                chk("led_b",  32'(led_b),  32'(x.led_b));
                chk("busy_b", 32'(busy_b), 32'(x.busy_b));
                chk("tick_b", 32'(tick_b), 32'(x.tick_b));
            end
        end
    end

    task automatic random_run(input int n);
        logic [NCH-1:0] cur;
        cur = en;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(11) == 0) cur[c] = ~cur[c];
            end
            cycle(cur);
        end
    endtask

    initial begin
        presetn = 1'b0;
        en      = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        presetn = 1'b1;
        drive_step('0);

        // held enable on channel 0
        repeat (40) cycle(4'b0001);
        repeat (12) cycle(4'b0000);
        // single-cycle enable pulse
        cycle(4'b0001);
        repeat (12) cycle(4'b0000);
        // channels 0 and 2 start together, channel 2 dropped three cycles later
        repeat (3) cycle(4'b0101);
        repeat (20) cycle(4'b0001);
        repeat (12) cycle(4'b0000);

        random_run(600);

        // asynchronous reset while every channel is lit
        repeat (12) cycle(4'b0000);
        cycle(4'hF);
        @(posedge clk);
        #3;
        presetn = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        @(negedge clk);
        presetn = 1'b1;
        drive_step(4'hF);
        repeat (30) cycle(4'hF);

        random_run(300);
        repeat (2) cycle(4'b0000);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
